regfile_operand_fetch: RTL and testbench

- Initiator side of the 128-bit wide-word register file's read interface (2 read ports, 1 byte-enabled write port).
- Accepts operand-fetch requests (two 5-bit register addresses plus a tag) and drives the register file read enables and addresses.
- Captures the returned 128-bit words and merges in-flight writeback bytes.
- Presents complete operand pairs to the execute stage through a valid/ready FIFO.

---
 rtl/regfile_operand_fetch.sv | 243 ++++++++++++++++++++++++
 tb/tb_regfile_operand_fetch.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_operand_fetch.sv
// -----------------------------------------------------------------------------
// regfile_operand_fetch
//
// Purpose:
//   Read-side initiator for a 128-bit wide-word register file with two read
//   ports and one byte-enabled write port. A fetch request (two register
//   addresses, two use flags and a tag) is turned into register-file read
//   enables in the issue cycle. The words returned in the next cycle are
//   optionally merged with in-flight writeback bytes and pushed, together with
//   the tag, into a small operand FIFO. The execute stage drains the FIFO
//   through a valid/ready handshake.
//
// Configuration macro:
//   OPFETCH_BYPASS_EN - when defined, writeback bytes seen in the issue cycle
//                       or the capture cycle are merged into the operands
//                       (capture-cycle write has priority). When undefined the
//                       wb_* inputs are ignored and operands are raw read data.
//
// Parameters:
//   DEPTH - operand FIFO entries (>=3 sustains one request per cycle)
//   TAGW  - request tag width
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/req_ready        fetch request handshake
//   req_ra1/req_ra2            operand register addresses
//   req_use1/req_use2          operand needed flags
//   req_tag                    opaque tag returned with the operands
//   rd1addr/rd2addr            register file read addresses (= req_ra1/2)
//   rd1en/rd2en                register file read enables
//   rd1data/rd2data            register file read data (valid cycle after en)
//   wb_en/wb_addr/wb_data/wb_byteen  snoop of the register file write port
//   op_valid/op_ready          operand FIFO head handshake
//   op1/op2/op_tag             operand FIFO head contents
// -----------------------------------------------------------------------------
module regfile_operand_fetch #(
  parameter int DEPTH = 3,
  parameter int TAGW  = 4
) (
  input  logic            clk,
  input  logic            reset,
  // fetch request
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_ra1,
  input  logic [4:0]      req_ra2,
  input  logic            req_use1,
  input  logic            req_use2,
  input  logic [TAGW-1:0] req_tag,
  // register file read ports
  output logic [4:0]      rd1addr,
  output logic [4:0]      rd2addr,
  output logic            rd1en,
  output logic            rd2en,
  input  logic [127:0]    rd1data,
  input  logic [127:0]    rd2data,
  // register file write port snoop
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [127:0]    wb_data,
  input  logic [15:0]     wb_byteen,
  // operand output
  output logic            op_valid,
  input  logic            op_ready,
  output logic [127:0]    op1,
  output logic [127:0]    op2,
  output logic [TAGW-1:0] op_tag
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One spare bit so count+pend never wraps.
  localparam int CW = $clog2(DEPTH + 1) + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            pend_q, pend_d;
  logic            pend_use1_q, pend_use2_q;
  logic [TAGW-1:0] pend_tag_q;

  logic [127:0]    fifo_op1_q [DEPTH];
  logic [127:0]    fifo_op2_q [DEPTH];
  logic [TAGW-1:0] fifo_tag_q [DEPTH];

  logic            accept;
  logic            push;
  logic            pop;
  logic [CW-1:0]   occupancy;
  logic [127:0]    merged1;
  logic [127:0]    merged2;
  logic [127:0]    push_op1;
  logic [127:0]    push_op2;

  // ---------------------------------------------------------------------------
  // Issue
  // ---------------------------------------------------------------------------
  // Occupancy counts the entry still in flight from the register file so
  // that a request is only accepted when its capture slot is guaranteed.
  assign occupancy = count_q + {{(CW-1){1'b0}}, pend_q};
  assign req_ready = (occupancy < CW'(DEPTH));
  assign accept    = req_valid && req_ready;

  assign rd1addr   = req_ra1;
  assign rd2addr   = req_ra2;
  assign rd1en     = accept && req_use1;
  assign rd2en     = accept && req_use2;

  // pend follows acceptance exactly: a capture every cycle after an accept.
  assign pend_d    = accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q      <= 1'b0;
      pend_use1_q <= 1'b0;
      pend_use2_q <= 1'b0;
      pend_tag_q  <= '0;
    end else begin
      pend_q <= pend_d;
      if (accept) begin
        pend_use1_q <= req_use1;
        pend_use2_q <= req_use2;
        pend_tag_q  <= req_tag;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Capture and writeback merge
  // ---------------------------------------------------------------------------
`ifdef OPFETCH_BYPASS_EN
  // Issue-cycle write: the register file returns the old data for a write on
  // the same edge as the read, so the write bytes are recorded per operand.
  logic [4:0]   pend_ra1_q, pend_ra2_q;
  logic [15:0]  pend_mask1_q, pend_mask2_q;
  logic [15:0]  pend_mask1_d, pend_mask2_d;
  logic [127:0] pend_wdata_q;
  logic         hit1_now, hit2_now;

  always_comb begin
    pend_mask1_d = '0;
    pend_mask2_d = '0;
    if (wb_en && (wb_addr == req_ra1)) pend_mask1_d = wb_byteen;
    if (wb_en && (wb_addr == req_ra2)) pend_mask2_d = wb_byteen;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_ra1_q   <= '0;
      pend_ra2_q   <= '0;
      pend_mask1_q <= '0;
      pend_mask2_q <= '0;
      pend_wdata_q <= '0;
    end else if (accept) begin
      pend_ra1_q   <= req_ra1;
      pend_ra2_q   <= req_ra2;
      pend_mask1_q <= pend_mask1_d;
      pend_mask2_q <= pend_mask2_d;
      pend_wdata_q <= wb_data;
    end
  end

  // Capture-cycle write hits the register being returned right now.
  assign hit1_now = wb_en && (wb_addr == pend_ra1_q);
  assign hit2_now = wb_en && (wb_addr == pend_ra2_q);

  // Per byte: capture-cycle write, then issue-cycle write, then read data.
  for (genvar gi = 0; gi < 16; gi++) begin : g_merge
    assign merged1[8*gi +: 8] =
      (hit1_now && wb_byteen[gi]) ? wb_data[8*gi +: 8]      :
      pend_mask1_q[gi]            ? pend_wdata_q[8*gi +: 8] :
                                    rd1data[8*gi +: 8];
    assign merged2[8*gi +: 8] =
      (hit2_now && wb_byteen[gi]) ? wb_data[8*gi +: 8]      :
      pend_mask2_q[gi]            ? pend_wdata_q[8*gi +: 8] :
                                    rd2data[8*gi +: 8];
  end
`else
  // Without the merge the writeback snoop carries no information we use;
  // the scheduler is responsible for spacing dependent reads.
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_addr, wb_data, wb_byteen};
  assign merged1   = rd1data;
  assign merged2   = rd2data;
`endif

  // Unused operands are forced to zero, regardless of any bypass.
  assign push_op1 = pend_use1_q ? merged1 : '0;
  assign push_op2 = pend_use2_q ? merged2 : '0;

  // ---------------------------------------------------------------------------
  // Operand FIFO
  // ---------------------------------------------------------------------------
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push     = pend_q;
  assign op_valid = (count_q != '0);
  assign pop      = op_valid && op_ready;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; a slot is only visible once counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op1_q[wr_ptr_q] <= push_op1;
      fifo_op2_q[wr_ptr_q] <= push_op2;
      fifo_tag_q[wr_ptr_q] <= pend_tag_q;
    end
  end

  // Head is presented directly; zero when empty so reset shows clean outputs.
  assign op1    = op_valid ? fifo_op1_q[rd_ptr_q] : '0;
  assign op2    = op_valid ? fifo_op2_q[rd_ptr_q] : '0;
  assign op_tag = op_valid ? fifo_tag_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
module tb_regfile_operand_fetch;

  localparam int DEPTH = 3;
  localparam int TAGW  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic [4:0]      req_ra1, req_ra2;
  logic            req_use1, req_use2;
  logic [TAGW-1:0] req_tag;
  logic [4:0]      rd1addr, rd2addr;
  logic            rd1en, rd2en;
  logic [127:0]    rd1data, rd2data;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [127:0]    wb_data;
  logic [15:0]     wb_byteen;
  logic            op_valid, op_ready;
  logic [127:0]    op1, op2;
  logic [TAGW-1:0] op_tag;

  regfile_operand_fetch #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ra1(req_ra1), .req_ra2(req_ra2),
    .req_use1(req_use1), .req_use2(req_use2), .req_tag(req_tag),
    .rd1addr(rd1addr), .rd2addr(rd2addr), .rd1en(rd1en), .rd2en(rd2en),
    .rd1data(rd1data), .rd2data(rd2data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_byteen(wb_byteen),
    .op_valid(op_valid), .op_ready(op_ready),
    .op1(op1), .op2(op2), .op_tag(op_tag)
  );

  always #5 clk = ~clk;

  // Register file model: read data the cycle after enable, old data on a
  // same-edge write/read collision.
  logic [127:0] regs [32];
  always @(posedge clk) begin : regfile_model
    logic [127:0] w;
    if (rd1en) rd1data <= regs[rd1addr];
    if (rd2en) rd2data <= regs[rd2addr];
    if (wb_en) begin
      w = regs[wb_addr];
      for (int i = 0; i < 16; i++)
        if (wb_byteen[i]) w[8*i +: 8] = wb_data[8*i +: 8];
      regs[wb_addr] <= w;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [127:0]    o1;
    logic [127:0]    o2;
    logic [TAGW-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cyc[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [127:0] R0 = 128'h787897ea12fec60cae787897eac22354;
  localparam logic [127:0] R7 = 128'hc65da4654cad646c5d4a564cd56ca552;
  localparam logic [127:0] R2 = 128'h0123456789abcdeffedcba9876543210;
  logic [127:0] pv [5];

`ifdef OPFETCH_BYPASS_EN
  localparam logic [127:0] EXP_SAME = {64'h0, 64'hFFFFFFFFFFFFFFFF};
  localparam logic [127:0] EXP_PRIO = 128'h11111111111111111111111111111122;
`else
  localparam logic [127:0] EXP_SAME = 128'h0;
  localparam logic [127:0] EXP_PRIO = R2;
`endif

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  task automatic chki(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [127:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d; wb_byteen = 16'hffff;
    @(posedge clk); #1;
    wb_en = 1'b0; wb_byteen = 16'h0;
  endtask

  // Presents one request until accepted; returns at accept edge + 1.
  task automatic issue(input logic [4:0] a1, input logic [4:0] a2,
                       input logic u1, input logic u2, input logic [TAGW-1:0] tg,
                       input logic [127:0] e1, input logic [127:0] e2,
                       input bit push_exp, output int stalls);
    bit   acc;
    exp_t ent;
    acc = 1'b0;
    stalls = 0;
    req_valid = 1'b1; req_ra1 = a1; req_ra2 = a2;
    req_use1 = u1; req_use2 = u2; req_tag = tg;
    for (int n = 0; n < 64 && !acc; n++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = 1'b1;
        chk1("rd1en", rd1en, u1);
        chk1("rd2en", rd2en, u2);
        total++;
        if (exp_q.size() >= DEPTH) begin
          bad++;
          $display("FAIL fifo_overflow: outstanding=%0d required <%0d", exp_q.size(), DEPTH);
        end
        if (push_exp) begin
          ent.o1 = e1; ent.o2 = e2; ent.tag = tg;
          exp_q.push_back(ent);
        end
        $display("issue tag=%0d ra1=%0d ra2=%0d use=%b%b", tg, a1, a2, u1, u2);
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL issue_timeout: tag=%0d accepted=0 required accepted=1", tg);
    end
  endtask

  initial begin
    int st;
    pv[0] = 128'h00000000111111112222222233333333;
    pv[1] = 128'h44444444555555556666666677777777;
    pv[2] = 128'h8888888899999999aaaaaaaabbbbbbbb;
    pv[3] = 128'hccccccccddddddddeeeeeeeeffffffff;
    pv[4] = 128'hdeadbeefcafef00d0123456789abcdef;

    reset = 1'b1; req_valid = 1'b0; req_ra1 = '0; req_ra2 = '0;
    req_use1 = 1'b0; req_use2 = 1'b0; req_tag = '0; op_ready = 1'b1;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; wb_byteen = '0;

    // Scoreboard monitor: pops an expectation whenever the DUT transfers.
    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (!reset && op_valid && op_ready) begin
            pop_cyc.push_back(cyc);
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL unexpected_op: tag=%0d presented, required no output", op_tag);
            end else begin
              e = exp_q.pop_front();
              if (op1 !== e.o1 || op2 !== e.o2 || op_tag !== e.tag) begin
                bad++;
                $display("FAIL op_tag%0d: op1=%h op2=%h tag=%0d required op1=%h op2=%h tag=%0d",
                         e.tag, op1, op2, op_tag, e.o1, e.o2, e.tag);
              end else begin
                $display("result tag=%0d op1=%h op2=%h", op_tag, op1, op2);
              end
            end
          end
        end
      end
    join_none

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_op_valid", op_valid, 1'b0);
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_rd1en", rd1en, 1'b0);
    chk1("rst_rd2en", rd2en, 1'b0);
    chk("rst_op1", op1, 128'h0);
    chk("rst_op2", op2, 128'h0);
    chki("rst_op_tag", int'(op_tag), 0);
    reset = 1'b0;

    // Preload register file through the write port.
    wb_write(5'd0, R0);
    wb_write(5'd7, R7);
    wb_write(5'd1, 128'h0);
    wb_write(5'd2, R2);
    wb_write(5'd3, 128'h3333);
    for (int k = 0; k < 5; k++) wb_write(5'(8 + k), pv[k]);
    repeat (2) @(posedge clk);
    #1;

    // Reset during an in-flight fetch discards it.
    issue(5'd3, 5'd0, 1'b1, 1'b0, 4'd7, 128'h0, 128'h0, 1'b0, st);
    reset = 1'b1;
    #1;
    chk1("midrst_op_valid", op_valid, 1'b0);
    chk1("midrst_req_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk1("midrst_no_push", op_valid, 1'b0);
    end
    chk1("midrst_ready_after", req_ready, 1'b1);
    @(posedge clk); #1;

    // Basic read with latency check.
    op_ready = 1'b0;
    issue(5'd0, 5'd7, 1'b1, 1'b1, 4'd5, R0, R7, 1'b1, st);
    @(negedge clk);
    chk1("lat_cycle1_valid", op_valid, 1'b0);
    @(negedge clk);
    chk1("lat_cycle2_valid", op_valid, 1'b1);
    @(posedge clk); #1;
    op_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Issue-cycle writeback to the source register.
    wb_en = 1'b1; wb_addr = 5'd1; wb_byteen = 16'h00ff; wb_data = {128{1'b1}};
    issue(5'd1, 5'd0, 1'b1, 1'b0, 4'd9, EXP_SAME, 128'h0, 1'b1, st);
    wb_en = 1'b0; wb_byteen = 16'h0;
    repeat (3) @(posedge clk);
    #1;

    // Writes in both the issue and capture cycles; capture cycle wins.
    // Operand 2 reads the same register but is unused, so stays zero.
    wb_en = 1'b1; wb_addr = 5'd2; wb_byteen = 16'hffff;
    wb_data = 128'h11111111111111111111111111111111;
    issue(5'd2, 5'd2, 1'b1, 1'b0, 4'd6, EXP_PRIO, 128'h0, 1'b1, st);
    wb_byteen = 16'h0001;
    wb_data = 128'h22222222222222222222222222222222;
    @(posedge clk); #1;
    wb_en = 1'b0; wb_byteen = 16'h0;
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: three accepts fill the FIFO, then req_ready drops.
    op_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      issue(5'(8 + k), 5'd7, 1'b1, 1'b1, 4'(k), pv[k], R7, 1'b1, st);
      chki("bp_accept_nostall", st, 0);
    end
    req_valid = 1'b1; req_ra1 = 5'd11; req_ra2 = 5'd7;
    req_use1 = 1'b1; req_use2 = 1'b1; req_tag = 4'd3;
    @(negedge clk);
    chk1("bp_ready_drop", req_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("bp_ready_hold", req_ready, 1'b0);
    @(posedge clk); #1;
    op_ready = 1'b1;
    issue(5'd11, 5'd7, 1'b1, 1'b1, 4'd3, pv[3], R7, 1'b1, st);
    issue(5'd12, 5'd7, 1'b1, 1'b1, 4'd4, pv[4], R7, 1'b1, st);
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
    repeat (3) @(posedge clk);
    #1;

    // Unused operand 2 and full throughput with op_ready held high.
    pop_cyc.delete();
    for (int k = 0; k < 4; k++) begin
      issue(5'(8 + k), 5'd7, 1'b1, 1'b0, 4'(10 + k), pv[k], 128'h0, 1'b1, st);
      chki("tp_accept_nostall", st, 0);
    end
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
    repeat (3) @(posedge clk);
    #1;
    chki("tp_result_count", pop_cyc.size(), 4);
    for (int i = 0; i + 1 < pop_cyc.size(); i++)
      chki("tp_result_spacing", pop_cyc[i+1] - pop_cyc[i], 1);

    chki("drain_scoreboard_empty", exp_q.size(), 0);
    chk1("drain_op_valid", op_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
